// File: rtl/vector_div16_if.sv
// Handshake and result bundle for the sequential divider.
// The requester drives start and the operands; the divider returns status and results.
interface vector_div16_if #(
  parameter int WIDTH = 16
);
  logic                 start;
  logic                 op_signed;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 div_zero;
  logic                 overflow;

  modport master (
    output start, op_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero, overflow
  );

  modport slave (
    input  start, op_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_zero, overflow
  );
endinterface

// File: rtl/vector_div16.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor.
// Works on magnitudes, one quotient bit per clock, then applies signs and
// saturation in a final fix-up step. Divide-by-zero skips the iterations.
module vector_div16 #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  vector_div16_if.slave bus
);
  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0]    LAST    = CW'(DW - 1);
  localparam logic [WIDTH-1:0] ALL1    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SETUP, ITER, FIX} state_t;

  state_t state_reg, state_next;

  // Visible results
  logic             busy_reg, done_reg, dz_reg, ov_reg;
  logic [WIDTH-1:0] q_reg, r_reg;

  // Work registers: dvd_reg holds the dividend and, shifted in from the
  // bottom, the quotient bits; rem_reg is the partial remainder magnitude.
  logic [DW-1:0]    dvd_reg;
  logic [WIDTH:0]   dvs_reg;
  logic [WIDTH:0]   rem_reg;
  logic [CW-1:0]    cnt_reg;
  logic             sgn_reg, sign_q_reg, sign_r_reg, zero_reg;

  logic             dvs_is_zero;
  logic [WIDTH+1:0] shifted, diff;
  logic             fits;
  logic             hi_nz, lo_rest_nz, lo_msb;
  logic [WIDTH-1:0] fix_q, fix_r;
  logic             fix_ov;

  assign dvs_is_zero = (dvs_reg[WIDTH-1:0] == '0);

  // One restoring step: bring in the next dividend bit, subtract if it fits
  always_comb begin
    shifted = {rem_reg, dvd_reg[DW-1]};
    diff    = shifted - {1'b0, dvs_reg};
    fits    = (shifted >= {1'b0, dvs_reg});
  end

  // Sign application, saturation and divide-by-zero results for the result edge
  always_comb begin
    hi_nz      = |dvd_reg[DW-1:WIDTH];
    lo_rest_nz = |dvd_reg[WIDTH-2:0];
    lo_msb     = dvd_reg[WIDTH-1];
    fix_q      = '0;
    fix_r      = '0;
    fix_ov     = 1'b0;
    if (zero_reg) begin
      // dvd_reg still holds the untouched dividend on this path
      fix_r = dvd_reg[WIDTH-1:0];
      fix_q = !sgn_reg ? ALL1 : (dvd_reg[DW-1] ? MIN_NEG : MAX_POS);
    end else if (!sgn_reg) begin
      fix_ov = hi_nz;
      fix_q  = hi_nz ? ALL1 : dvd_reg[WIDTH-1:0];
      fix_r  = rem_reg[WIDTH-1:0];
    end else begin
      fix_r = sign_r_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
      if (sign_q_reg) begin
        // negative result may reach exactly 2^(WIDTH-1) in magnitude
        fix_ov = hi_nz | (lo_msb & lo_rest_nz);
        fix_q  = fix_ov ? MIN_NEG : -dvd_reg[WIDTH-1:0];
      end else begin
        fix_ov = hi_nz | lo_msb;
        fix_q  = fix_ov ? MAX_POS : dvd_reg[WIDTH-1:0];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = SETUP;
      SETUP:   state_next = dvs_is_zero ? FIX : ITER;
      ITER:    if (cnt_reg == LAST) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      dz_reg     <= 1'b0;
      ov_reg     <= 1'b0;
      q_reg      <= '0;
      r_reg      <= '0;
      dvd_reg    <= '0;
      dvs_reg    <= '0;
      rem_reg    <= '0;
      cnt_reg    <= '0;
      sgn_reg    <= 1'b0;
      sign_q_reg <= 1'b0;
      sign_r_reg <= 1'b0;
      zero_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            dvd_reg  <= bus.dividend;
            dvs_reg  <= {1'b0, bus.divisor};
            sgn_reg  <= bus.op_signed;
            zero_reg <= 1'b0;
            busy_reg <= 1'b1;
          end
        end
        SETUP: begin
          sign_q_reg <= sgn_reg & (dvd_reg[DW-1] ^ dvs_reg[WIDTH-1]);
          sign_r_reg <= sgn_reg & dvd_reg[DW-1];
          rem_reg    <= '0;
          cnt_reg    <= '0;
          if (dvs_is_zero) begin
            zero_reg <= 1'b1;
          end else begin
            if (sgn_reg && dvd_reg[DW-1]) dvd_reg <= -dvd_reg;
            if (sgn_reg && dvs_reg[WIDTH-1])
              dvs_reg <= {1'b0, ~dvs_reg[WIDTH-1:0]} + (WIDTH+1)'(1);
          end
        end
        ITER: begin
          rem_reg <= fits ? diff[WIDTH:0] : shifted[WIDTH:0];
          dvd_reg <= {dvd_reg[DW-2:0], fits};
          cnt_reg <= cnt_reg + CW'(1);
        end
        FIX: begin
          q_reg    <= fix_q;
          r_reg    <= fix_r;
          ov_reg   <= fix_ov;
          dz_reg   <= zero_reg;
          done_reg <= 1'b1;
          busy_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.quotient  = q_reg;
  assign bus.remainder = r_reg;
  assign bus.div_zero  = dz_reg;
  assign bus.overflow  = ov_reg;
endmodule

// File: tb/tb_vector_div16.sv
// Bench for vector_div16: directed cases, protocol cases and a random sweep.
// Expected results are queued when an operation is issued and popped at done.
module tb_vector_div16;
  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        ov;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  res_t sb[$];

  vector_div16_if #(.WIDTH(16)) bus ();
  vector_div16 #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic with truncation toward zero
  function automatic res_t model(input bit sgn, input logic [31:0] dvd, input logic [15:0] dvs);
    res_t   e;
    longint a, b, qq, rr;
    e = '0;
    if (dvs == 16'h0) begin
      e.dz = 1'b1;
      e.r  = dvd[15:0];
      e.q  = !sgn ? 16'hFFFF : (dvd[31] ? 16'h8000 : 16'h7FFF);
    end else if (!sgn) begin
      a = longint'(dvd);
      b = longint'(dvs);
      qq = a / b;
      rr = a % b;
      e.ov = (qq > 65535);
      e.q  = e.ov ? 16'hFFFF : 16'(qq);
      e.r  = 16'(rr);
    end else begin
      a = longint'($signed(dvd));
      b = longint'($signed(dvs));
      qq = a / b;
      rr = a % b;
      if (qq > 32767) begin
        e.ov = 1'b1; e.q = 16'h7FFF;
      end else if (qq < -32768) begin
        e.ov = 1'b1; e.q = 16'h8000;
      end else begin
        e.q = 16'(qq);
      end
      e.r = 16'(rr);
    end
    return e;
  endfunction

  // Drive one request for one cycle; caller is positioned at a negedge
  task automatic issue(input bit sgn, input logic [31:0] dvd, input logic [15:0] dvs, input res_t e);
    bus.start     = 1'b1;
    bus.op_signed = sgn;
    bus.dividend  = dvd;
    bus.divisor   = dvs;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Wait (bounded) for done; lat counts edges including the accepting one
  task automatic collect(input int n0, output res_t obs, output int lat);
    int n;
    n = n0;
    while (bus.done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    obs = {bus.quotient, bus.remainder, bus.div_zero, bus.overflow};
    lat = n;
    $display("txn q=%h r=%h dz=%b ov=%b latency=%0d", obs.q, obs.r, obs.dz, obs.ov, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_zero, bus.overflow} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h dz=%b ov=%b, expected all 0",
               bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_zero, bus.overflow);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got busy=%b done=%b, expected 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_unsigned();
    res_t obs, e;
    int   lat;
    bit          sg [2] = '{1'b0, 1'b0};
    logic [31:0] dd [2] = '{32'h0000_0064, 32'h0000_FFFF};
    logic [15:0] ds [2] = '{16'h0007, 16'hFFFF};
    res_t        ex [2] = '{'{16'h000E, 16'h0002, 1'b0, 1'b0}, '{16'h0001, 16'h0000, 1'b0, 1'b0}};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      issue(sg[i], dd[i], ds[i], ex[i]);
      n_checks++;
      if (bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL unsigned_busy_%0d: got busy=%b, expected 1", i, bus.busy);
      end
      collect(1, obs, lat);
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL unsigned_%0d: got q=%h r=%h dz=%b ov=%b, expected q=%h r=%h dz=%b ov=%b",
                 i, obs.q, obs.r, obs.dz, obs.ov, e.q, e.r, e.dz, e.ov);
      end
      n_checks++;
      if (lat !== 35 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL unsigned_latency_%0d: got %0d edges busy=%b, expected 35 edges busy=0", i, lat, bus.busy);
      end
    end
  endtask

  task automatic test_signed();
    res_t obs, e;
    int   lat;
    bit          sg [2] = '{1'b1, 1'b1};
    logic [31:0] dd [2] = '{32'hFFFF_FF9C, 32'h0000_0064};
    logic [15:0] ds [2] = '{16'h0007, 16'hFFF9};
    res_t        ex [2] = '{'{16'hFFF2, 16'hFFFE, 1'b0, 1'b0}, '{16'hFFF2, 16'h0002, 1'b0, 1'b0}};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      issue(sg[i], dd[i], ds[i], ex[i]);
      collect(1, obs, lat);
      e = sb.pop_front();
      n_checks++;
      if (obs !== e || lat !== 35) begin
        n_fail++;
        $display("FAIL signed_%0d: got q=%h r=%h dz=%b ov=%b lat=%0d, expected q=%h r=%h dz=%b ov=%b lat=35",
                 i, obs.q, obs.r, obs.dz, obs.ov, lat, e.q, e.r, e.dz, e.ov);
      end
    end
  endtask

  task automatic test_div_zero();
    res_t obs, e;
    int   lat;
    bit          sg [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] dd [3] = '{32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'h0000_1234};
    logic [15:0] ds [3] = '{16'h0000, 16'h0000, 16'h0000};
    res_t        ex [3] = '{'{16'h8000, 16'hFFF0, 1'b1, 1'b0}, '{16'hFFFF, 16'hFFF0, 1'b1, 1'b0},
                            '{16'h7FFF, 16'h1234, 1'b1, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      issue(sg[i], dd[i], ds[i], ex[i]);
      collect(1, obs, lat);
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL div_zero_%0d: got q=%h r=%h dz=%b ov=%b, expected q=%h r=%h dz=%b ov=%b",
                 i, obs.q, obs.r, obs.dz, obs.ov, e.q, e.r, e.dz, e.ov);
      end
      n_checks++;
      if (lat !== 3) begin
        n_fail++;
        $display("FAIL div_zero_latency_%0d: got %0d edges, expected 3", i, lat);
      end
    end
  endtask

  task automatic test_overflow();
    res_t obs, e;
    int   lat;
    bit          sg [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] dd [4] = '{32'hFFFF_8000, 32'hFFFF_8000, 32'h0001_0000, 32'h7FFF_FFFF};
    logic [15:0] ds [4] = '{16'hFFFF, 16'h0001, 16'h0001, 16'h8000};
    res_t        ex [4] = '{'{16'h7FFF, 16'h0000, 1'b0, 1'b1}, '{16'h8000, 16'h0000, 1'b0, 1'b0},
                            '{16'hFFFF, 16'h0000, 1'b0, 1'b1}, '{16'h8000, 16'h7FFF, 1'b0, 1'b1}};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      issue(sg[i], dd[i], ds[i], ex[i]);
      collect(1, obs, lat);
      e = sb.pop_front();
      n_checks++;
      if (obs !== e || lat !== 35) begin
        n_fail++;
        $display("FAIL overflow_%0d: got q=%h r=%h dz=%b ov=%b lat=%0d, expected q=%h r=%h dz=%b ov=%b lat=35",
                 i, obs.q, obs.r, obs.dz, obs.ov, lat, e.q, e.r, e.dz, e.ov);
      end
    end
  endtask

  task automatic test_busy_ignore();
    res_t obs, e;
    int   lat;
    bit   extra_done;
    @(negedge clk);
    issue(1'b0, 32'd1000, 16'd3, '{16'd333, 16'd1, 1'b0, 1'b0});
    repeat (5) @(negedge clk);
    bus.start = 1'b1; bus.op_signed = 1'b1; bus.dividend = 32'hFFFF_FFFF; bus.divisor = 16'h0000;
    @(negedge clk);
    bus.start = 1'b0;
    collect(7, obs, lat);
    e = sb.pop_front();
    n_checks++;
    if (obs !== e || lat !== 35) begin
      n_fail++;
      $display("FAIL busy_ignore: got q=%h r=%h dz=%b ov=%b lat=%0d, expected q=%h r=%h dz=%b ov=%b lat=35",
               obs.q, obs.r, obs.dz, obs.ov, lat, e.q, e.r, e.dz, e.ov);
    end
    extra_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra_done = 1'b1;
    end
    n_checks++;
    if (extra_done || bus.quotient !== 16'd333 || bus.remainder !== 16'd1) begin
      n_fail++;
      $display("FAIL busy_ignore_after: got extra_activity=%b q=%h r=%h, expected 0 q=014d r=0001",
               extra_done, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_back_to_back();
    res_t obs, e;
    int   lat;
    @(negedge clk);
    issue(1'b0, 32'h0000_0064, 16'h0007, '{16'h000E, 16'h0002, 1'b0, 1'b0});
    collect(1, obs, lat);
    e = sb.pop_front();
    n_checks++;
    if (obs !== e || lat !== 35) begin
      n_fail++;
      $display("FAIL b2b_first: got q=%h r=%h lat=%0d, expected q=%h r=%h lat=35", obs.q, obs.r, lat, e.q, e.r);
    end
    // issued in the done cycle itself
    issue(1'b1, 32'hFFFF_FF9C, 16'h0007, '{16'hFFF2, 16'hFFFE, 1'b0, 1'b0});
    collect(1, obs, lat);
    e = sb.pop_front();
    n_checks++;
    if (obs !== e || lat !== 35) begin
      n_fail++;
      $display("FAIL b2b_second: got q=%h r=%h lat=%0d, expected q=%h r=%h lat=35", obs.q, obs.r, lat, e.q, e.r);
    end
  endtask

  task automatic test_reset_mid();
    res_t obs, e;
    int   lat;
    bit   saw_done;
    @(negedge clk);
    issue(1'b0, 32'h0012_3456, 16'h0101, model(1'b0, 32'h0012_3456, 16'h0101));
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    e = sb.pop_back();
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_zero, bus.overflow} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b q=%h r=%h dz=%b ov=%b, expected all 0",
               bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_zero, bus.overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: got done pulse=1, expected 0");
    end
    issue(1'b1, 32'h0000_0064, 16'hFFF9, '{16'hFFF2, 16'h0002, 1'b0, 1'b0});
    collect(1, obs, lat);
    e = sb.pop_front();
    n_checks++;
    if (obs !== e || lat !== 35) begin
      n_fail++;
      $display("FAIL reset_mid_fresh: got q=%h r=%h lat=%0d, expected q=%h r=%h lat=35", obs.q, obs.r, lat, e.q, e.r);
    end
  endtask

  task automatic test_random();
    res_t        obs, e;
    int          lat;
    bit          sg;
    logic [31:0] dd;
    logic [15:0] ds;
    for (int i = 0; i < 24; i++) begin
      sg = 1'($urandom_range(0, 1));
      ds = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       dd = $urandom;
        1:       dd = {{16{ds[15] ^ sg}}, 16'($urandom)};
        2:       dd = 32'($urandom_range(0, 300000));
        default: dd = {{17{1'($urandom_range(0, 1))}}, 15'($urandom)};
      endcase
      if ($urandom_range(0, 9) == 0) ds = 16'h0;
      @(negedge clk);
      issue(sg, dd, ds, model(sg, dd, ds));
      collect(1, obs, lat);
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL random_%0d (sgn=%b %h/%h): got q=%h r=%h dz=%b ov=%b, expected q=%h r=%h dz=%b ov=%b",
                 i, sg, dd, ds, obs.q, obs.r, obs.dz, obs.ov, e.q, e.r, e.dz, e.ov);
      end
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.op_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
